register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32-entry general-purpose register file for the RV32 core.
- Sits directly upstream of the ALU and supplies its two operands, a and b.
- Also accepts the writeback result, typically the ALU result, on one write port.
- Register x0 reads as zero at all times; an optional same-cycle write-through bypass serves single-cycle datapaths.

Parameters:
N, 32, data width of each register and of every data port.
N_REGS, 32, number of registers; address width is $clog2(N_REGS).
WRITE_FIRST, 0, 1 = a read of the register being written in the same cycle returns the new data; 0 = it returns the old data.

Ports:
clk  input  1  system clock; all state updates occur on the rising edge.
rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
wr_ena  input  1  write enable for the write port.
wr_addr  input  5  destination register index.
wr_data  input  N  data to write.
rd_addr0  input  5  source register index for read port 0 (ALU operand a).
rd_data0  output  N  contents of register rd_addr0.
rd_addr1  input  5  source register index for read port 1 (ALU operand b).
rd_data1  output  N  contents of register rd_addr1.

Behaviour:
- Storage: N_REGS x N-bit registers, updated only on the rising edge of clk.
- Reset: if rst=1 at a rising edge, all registers become 0 at that edge.
  - rst has priority over a simultaneous write; that write is dropped.
  - Outputs are combinational from storage, so rd_data0 and rd_data1 read 0 after a reset edge.
- Write:
  - On a rising edge with rst=0, wr_ena=1 and wr_addr != 0, register[wr_addr] <= wr_data.
  - With wr_ena=0, no register changes.
- x0:
  - A write with wr_addr=0 is ignored.
  - Reading address 0 always returns 0, including under WRITE_FIRST bypass.
- Read:
  - Both ports are fully combinational (asynchronous) from address to data, with zero-cycle latency.
  - The two ports are independent; both may read the same address.
- Read-during-write, where rd_addrX == wr_addr != 0 and wr_ena=1 in the same cycle:
  - WRITE_FIRST=0: rd_dataX shows the pre-edge value; the new value is visible after the edge.
  - WRITE_FIRST=1: rd_dataX = wr_data combinationally in the same cycle, and the same value persists after the edge.
  - The bypass is suppressed while rst=1.
- Width rules:
  - The address width is fixed at 5 for N_REGS=32.
  - For smaller N_REGS, addresses >= N_REGS read 0 and writes to them are ignored.
- Outputs never take X after the first reset edge. Before the first reset, contents are undefined; the bench must reset first.
- No handshake; the block accepts a write every cycle.

Test Plan:
- Reset with garbage contents: write 0xDEADBEEF to x5, assert rst for 1 cycle, read x5 on both ports -> rd_data0 = rd_data1 = 0x00000000.
- Basic write/read: write x1=0x00000007 and x2=0xFFFFFFF9 on consecutive cycles; rd_addr0=1, rd_addr1=2 -> 0x00000007 / 0xFFFFFFF9. The ALU fed from these outputs with ADD yields 0x00000000 and zero=1.
- x0 immutability: write wr_addr=0, wr_data=0x12345678, wr_ena=1; read x0 on both ports -> 0x00000000 both before and after the edge, for both WRITE_FIRST settings.
- Read-during-write: x3=0x00000001, then write x3=0x80000000 while rd_addr0=3.
  - WRITE_FIRST=0: pre-edge read 0x00000001, post-edge 0x80000000.
  - WRITE_FIRST=1: 0x80000000 both pre-edge and post-edge.
- Reset vs write collision: rst=1 and wr_ena=1 (x4=0xAAAA5555) at the same edge -> x4 reads 0 afterwards. With rst=1 and WRITE_FIRST=1, the bypass does not show 0xAAAA5555.
- Random soak: 1000 cycles of random wr_ena/addresses/data checked against a behavioural array model with x0 forced to 0; both ports are checked every cycle (1 ns after the inputs change) -> zero mismatches.

Source files
------------

// File: rtl/register_file.sv
// RV32 general-purpose register file: one write port, two asynchronous read ports, x0 hardwired to zero.
// WRITE_FIRST=1 adds a same-cycle write-through bypass for single-cycle datapaths.
module register_file #(
  parameter int N           = 32,
  parameter int N_REGS      = 32,
  parameter bit WRITE_FIRST = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_wr_ena,
  input  logic [4:0]   i_wr_addr,
  input  logic [N-1:0] i_wr_data,
  input  logic [4:0]   i_rd_addr0,
  output logic [N-1:0] o_rd_data0,
  input  logic [4:0]   i_rd_addr1,
  output logic [N-1:0] o_rd_data1
);

  logic [N-1:0] r_regs [N_REGS];
  logic         w_wrValid;
  logic [4:0]   w_rdAddr [2];
  logic [N-1:0] w_rdData [2];

  // Writes to x0 or to addresses beyond the implemented registers are dropped.
  assign w_wrValid = i_wr_ena && (i_wr_addr != 5'd0) && (int'(i_wr_addr) < N_REGS);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wrValid) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  assign w_rdAddr[0] = i_rd_addr0;
  assign w_rdAddr[1] = i_rd_addr1;

  // The bypass reuses w_wrValid, so it never forwards to x0 and is masked while reset is asserted.
  for (genvar p = 0; p < 2; p++) begin : g_rdPort
    always_comb begin
      w_rdData[p] = '0;
      if ((w_rdAddr[p] != 5'd0) && (int'(w_rdAddr[p]) < N_REGS)) begin
        if (WRITE_FIRST && !i_rst && w_wrValid && (w_rdAddr[p] == i_wr_addr)) begin
          w_rdData[p] = i_wr_data;
        end else begin
          w_rdData[p] = r_regs[w_rdAddr[p]];
        end
      end
    end
  end

  assign o_rd_data0 = w_rdData[0];
  assign o_rd_data1 = w_rdData[1];

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: drives a read-first and a write-first instance with shared inputs
// and checks both against table constants and a behavioural array model through a scoreboard queue.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        wrEna;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [4:0]  rdAddr0;
  logic [4:0]  rdAddr1;
  logic [31:0] rfData0, rfData1, wfData0, wfData1;

  int assertCount = 0;
  int failCount   = 0;

  register_file #(.N(32), .N_REGS(32), .WRITE_FIRST(1'b0)) dutReadFirst (
    .i_clk(clk), .i_rst(rst), .i_wr_ena(wrEna), .i_wr_addr(wrAddr), .i_wr_data(wrData),
    .i_rd_addr0(rdAddr0), .o_rd_data0(rfData0), .i_rd_addr1(rdAddr1), .o_rd_data1(rfData1)
  );

  register_file #(.N(32), .N_REGS(32), .WRITE_FIRST(1'b1)) dutWriteFirst (
    .i_clk(clk), .i_rst(rst), .i_wr_ena(wrEna), .i_wr_addr(wrAddr), .i_wr_data(wrData),
    .i_rd_addr0(rdAddr0), .o_rd_data0(wfData0), .i_rd_addr1(rdAddr1), .o_rd_data1(wfData1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rf0;
    logic [31:0] rf1;
    logic [31:0] wf0;
    logic [31:0] wf1;
  } expect_t;

  typedef struct {
    string       tag;
    logic        rst;
    logic        ena;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] rf0;
    logic [31:0] rf1;
    logic [31:0] wf0;
    logic [31:0] wf1;
  } vector_t;

  expect_t     sbQueue[$];
  logic [31:0] model [32];

  function automatic logic [31:0] modelRead(input logic [4:0] ra, input bit writeFirst);
    if (ra == 5'd0) return 32'h0;
    if (writeFirst && !rst && wrEna && (wrAddr == ra)) return wrData;
    return model[ra];
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Pops the oldest expectation and compares all four read ports against it.
  task automatic checkOutput();
    expect_t e;
    if (sbQueue.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
      return;
    end
    e = sbQueue.pop_front();
    checkValue({e.tag, "/rf0"}, rfData0, e.rf0);
    checkValue({e.tag, "/rf1"}, rfData1, e.rf1);
    checkValue({e.tag, "/wf0"}, wfData0, e.wf0);
    checkValue({e.tag, "/wf1"}, wfData1, e.wf1);
  endtask

  // Drives one cycle of inputs just after a rising edge, checks the combinational reads 1 ns
  // later, then advances the model and the clock past the next edge.
  task automatic applyStimulus(input string tag, input logic r, input logic en, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [4:0] ra0, input logic [4:0] ra1,
                               input bit useTable, input expect_t tableExp);
    expect_t e;
    rst = r; wrEna = en; wrAddr = wa; wrData = wd; rdAddr0 = ra0; rdAddr1 = ra1;
    if (useTable) begin
      e = tableExp;
    end else begin
      e.tag = tag;
      e.rf0 = modelRead(ra0, 1'b0);
      e.rf1 = modelRead(ra1, 1'b0);
      e.wf0 = modelRead(ra0, 1'b1);
      e.wf1 = modelRead(ra1, 1'b1);
    end
    sbQueue.push_back(e);
    #1;
    checkOutput();
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (en && wa != 5'd0) begin
      model[wa] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  vector_t vecs[$];

  function automatic vector_t mkVec(input string tag, input logic r, input logic en, input logic [4:0] wa,
                                    input logic [31:0] wd, input logic [4:0] ra0, input logic [4:0] ra1,
                                    input logic [31:0] rf0, input logic [31:0] rf1,
                                    input logic [31:0] wf0, input logic [31:0] wf1);
    vector_t v;
    v.tag = tag; v.rst = r; v.ena = en; v.wa = wa; v.wd = wd; v.ra0 = ra0; v.ra1 = ra1;
    v.rf0 = rf0; v.rf1 = rf1; v.wf0 = wf0; v.wf1 = wf1;
    return v;
  endfunction

  initial begin
    expect_t     te;
    logic [31:0] sum;
    logic        r, en;
    logic [4:0]  wa, ra0, ra1;
    logic [31:0] wd;

    //                 tag            rst  ena  wa     wd            ra0 ra1 rf0           rf1           wf0           wf1
    vecs.push_back(mkVec("garbage_wr", 0, 1, 5'd5, 32'hDEADBEEF, 5, 5, 32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF));
    vecs.push_back(mkVec("rst_pre",    1, 0, 5'd0, 32'h0,        5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF));
    vecs.push_back(mkVec("rst_post",   0, 0, 5'd0, 32'h0,        5, 5, 32'h0,        32'h0,        32'h0,        32'h0));
    vecs.push_back(mkVec("wr_x1",      0, 1, 5'd1, 32'h00000007, 1, 2, 32'h0,        32'h0,        32'h7,        32'h0));
    vecs.push_back(mkVec("wr_x2",      0, 1, 5'd2, 32'hFFFFFFF9, 1, 2, 32'h7,        32'h0,        32'h7,        32'hFFFFFFF9));
    vecs.push_back(mkVec("rd_x1x2",    0, 0, 5'd0, 32'h0,        1, 2, 32'h7,        32'hFFFFFFF9, 32'h7,        32'hFFFFFFF9));
    vecs.push_back(mkVec("wr_x0_pre",  0, 1, 5'd0, 32'h12345678, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0));
    vecs.push_back(mkVec("wr_x0_post", 0, 0, 5'd0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0));
    vecs.push_back(mkVec("wr_x3_init", 0, 1, 5'd3, 32'h00000001, 3, 3, 32'h0,        32'h0,        32'h1,        32'h1));
    vecs.push_back(mkVec("rdw_x3_pre", 0, 1, 5'd3, 32'h80000000, 3, 1, 32'h1,        32'h7,        32'h80000000, 32'h7));
    vecs.push_back(mkVec("rdw_x3_post",0, 0, 5'd0, 32'h0,        3, 3, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000));
    vecs.push_back(mkVec("rst_wr_x4",  1, 1, 5'd4, 32'hAAAA5555, 4, 4, 32'h0,        32'h0,        32'h0,        32'h0));
    vecs.push_back(mkVec("rst_wr_post",0, 0, 5'd0, 32'h0,        4, 3, 32'h0,        32'h0,        32'h0,        32'h0));

    // Contents are undefined until the first reset edge, so nothing is checked here.
    rst = 1'b1; wrEna = 1'b0; wrAddr = '0; wrData = '0; rdAddr0 = '0; rdAddr1 = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      te.tag = vecs[i].tag; te.rf0 = vecs[i].rf0; te.rf1 = vecs[i].rf1;
      te.wf0 = vecs[i].wf0; te.wf1 = vecs[i].wf1;
      applyStimulus(vecs[i].tag, vecs[i].rst, vecs[i].ena, vecs[i].wa, vecs[i].wd,
                    vecs[i].ra0, vecs[i].ra1, 1'b1, te);
    end

    // ALU operands: x1 + x2 must wrap to zero with the zero flag set.
    applyStimulus("alu_wr_x1", 0, 1, 5'd1, 32'h00000007, 5'd1, 5'd2, 1'b0, te);
    applyStimulus("alu_wr_x2", 0, 1, 5'd2, 32'hFFFFFFF9, 5'd1, 5'd2, 1'b0, te);
    rst = 1'b0; wrEna = 1'b0; rdAddr0 = 5'd1; rdAddr1 = 5'd2;
    #1;
    sum = rfData0 + rfData1;
    checkValue("alu_add_result", sum, 32'h0);
    checkValue("alu_zero_flag", {31'h0, (sum == 32'h0)}, 32'h1);
    @(posedge clk);
    #1;

    // Back-to-back writes to one register while both ports watch it.
    for (int k = 0; k < 6; k++) begin
      applyStimulus("b2b_x7", 0, 1, 5'd7, 32'h1000 + k, 5'd7, 5'd7, 1'b0, te);
    end

    for (int c = 0; c < 1000; c++) begin
      r   = ($urandom_range(0, 63) == 0);
      en  = $urandom_range(0, 1);
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      applyStimulus("soak", r, en, wa, wd, ra0, ra1, 1'b0, te);
    end

    assertCount++;
    if (sbQueue.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries, expected 0", sbQueue.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
